math_addsub_multiword_seq: RTL
==============================

Name: math_addsub_multiword_seq

Overview:
- Sequencer for wide integer add/subtract: computes a W = N*WORDS bit add or subtract using one shared N-bit full add/sub datapath, one word per cycle, LSW first.
- Carry/borrow is registered between words, so a wide operation costs WORDS cycles and needs only N bits of carry chain.
- Sits between a valid/ready requester (ALU front end, accumulator) and the result consumer. The datapath is instantiated inside this block.

Parameters:
- N, 8, word width of the internal add/sub datapath (>=1).
- WORDS, 4, number of words per operation (>=2). Derived localparams: W = N*WORDS; CW = $clog2(WORDS).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request (high only in IDLE).
- i_a  input  W  operand A.
- i_b  input  W  operand B.
- i_sub  input  1  0 = A+B, 1 = A-B.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_sum  output  W  result, modulo 2^W.
- o_carry  output  1  final carry-out of MSW. For subtract, 1 = no borrow and 0 = borrow.
- o_ovf  output  1  signed two's-complement overflow.
- o_busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, any state): state = IDLE; o_valid, o_sum, o_carry, o_ovf, o_busy = 0; o_ready = 1. Internal operand regs, word index and carry reg = 0. Reset mid-RUN/DONE abandons the operation; no partial result is ever flagged valid.
- States:
  - IDLE: o_ready = 1. On edge with i_valid & o_ready: latch i_a, i_b, i_sub; carry reg <= i_sub; idx <= 0; go to RUN.
  - RUN (WORDS cycles): datapath inputs are a_word = A[idx*N +: N], b_word = B[idx*N +: N] ^ {N{sub}}, cin = carry reg.
    - Each edge: o_sum[idx*N +: N] <= sum_word; carry reg <= cout; idx <= idx+1.
    - On the edge with idx == WORDS-1: o_carry <= cout; o_ovf <= (a_msb == b'_msb) & (sum_msb != a_msb), where b' is the inverted B when sub = 1; go to DONE.
  - DONE: o_valid = 1. o_sum, o_carry and o_ovf are held stable until an edge with i_ready = 1, which returns to IDLE (o_valid = 0, o_ready = 1 next cycle).
- Latency: accept at edge k gives o_valid high after edge k+WORDS. Minimum throughput is one operation per WORDS+2 cycles (no accept in the same cycle a result is consumed).
- i_valid while busy: ignored. i_a/i_b changes after accept do not affect the result.
- o_sum words not yet written during RUN are don't-care. Only o_valid qualifies output data.
- Word index counts 0..WORDS-1 and never wraps within an operation. WORDS need not be a power of 2.
- All outputs are registered except o_ready and o_busy, which are decoded from state.

Test Plan (N=8, WORDS=4, W=32):
- Add 0xFFFFFFFF + 0x00000001, i_sub=0 -> o_sum=0x00000000, o_carry=1, o_ovf=0; o_valid exactly 4 cycles after accept.
- Sub 0x00000000 - 0x00000001 -> o_sum=0xFFFFFFFF, o_carry=0 (borrow), o_ovf=0.
- Add 0x7FFFFFFF + 0x00000001 -> o_sum=0x80000000, o_carry=0, o_ovf=1. Sub 0x80000000 - 0x00000001 -> o_sum=0x7FFFFFFF, o_carry=1, o_ovf=1.
- Backpressure: hold i_ready=0 for 3 cycles in DONE while i_valid=1 with new operands -> outputs stable, o_ready=0, new request not taken. After i_ready=1, o_ready=1 on the next cycle and the new request completes correctly.
- Carry chain: 0x00FF00FF + 0x00010001 -> 0x01000100 (carry crosses word boundaries twice), o_carry=0.
- Assert i_rst_n=0 asynchronously after 2 RUN cycles -> immediately o_valid=0, o_busy=0, o_ready=1. After release, 0x12345678 + 0x11111111 -> 0x23456789.
- Random: 1000 random operand/i_sub sets -> {o_carry, o_sum} matches the 33-bit reference model; o_ovf matches the signed check.

Source files
------------

// File: rtl/math_addsub_multiword_seq.sv
// math_addsub_multiword_seq: wide add/subtract computed one N-bit word per cycle, LSW first,
// with the carry/borrow registered between words.
module math_addsub_multiword_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [N*WORDS-1:0]   i_a,
  input  logic [N*WORDS-1:0]   i_b,
  input  logic                 i_sub,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [N*WORDS-1:0]   o_sum,
  output logic                 o_carry,
  output logic                 o_ovf,
  output logic                 o_busy
);
  localparam int W  = N * WORDS;
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_a, r_b;
  logic            r_sub, r_c;
  logic [CW-1:0]   r_idx;
  logic [N-1:0]    w_a_word, w_b_word, w_sum;
  logic            w_cout, w_last;

  assign w_a_word = r_a[r_idx*N +: N];
  assign w_b_word = r_b[r_idx*N +: N] ^ {N{r_sub}};
  assign {w_cout, w_sum} = {1'b0, w_a_word} + {1'b0, w_b_word} + {{N{1'b0}}, r_c};
  assign w_last = (r_idx == CW'(WORDS - 1));
  assign o_ready = (r_state == S_IDLE);
  assign o_busy  = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = i_valid ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = i_ready ? S_IDLE : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_c     <= 1'b0;
      r_idx   <= '0;
      o_sum   <= '0;
      o_carry <= 1'b0;
      o_ovf   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && i_valid) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_sub <= i_sub;
        r_c   <= i_sub;
        r_idx <= '0;
      end
      if (r_state == S_RUN) begin
        o_sum[r_idx*N +: N] <= w_sum;
        r_c   <= w_cout;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          // signed overflow: operands agree in sign but the result does not
          o_carry <= w_cout;
          o_ovf   <= (w_a_word[N-1] == w_b_word[N-1]) && (w_sum[N-1] != w_a_word[N-1]);
          o_valid <= 1'b1;
        end
      end
      if (r_state == S_DONE && i_ready)
        o_valid <= 1'b0;
    end
  end
endmodule
